// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: load/store type codes,
// write-back source codes and the FSM state encoding.
package lsu_pkg;

    // Load type codes (Ld_cntr_exe2lsu); 110/111 behave as no load.
    localparam logic [2:0] LD_NONE = 3'b000;
    localparam logic [2:0] LD_LB   = 3'b001;
    localparam logic [2:0] LD_LH   = 3'b010;
    localparam logic [2:0] LD_LW   = 3'b011;
    localparam logic [2:0] LD_LBU  = 3'b100;
    localparam logic [2:0] LD_LHU  = 3'b101;

    // Store type codes (St_cntr_exe2lsu).
    localparam logic [1:0] ST_NONE = 2'b00;
    localparam logic [1:0] ST_SB   = 2'b01;
    localparam logic [1:0] ST_SH   = 2'b10;
    localparam logic [1:0] ST_SW   = 2'b11;

    // Write-back source (Memtoreg_exe2lsu); every other code selects alu_result.
    localparam logic [1:0] MTR_LOAD = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10
    } lsu_state_t;

    // True for the five load codes that actually access memory.
    function automatic logic is_load_code(input logic [2:0] ld);
        return (ld == LD_LB) || (ld == LD_LH) || (ld == LD_LW) ||
               (ld == LD_LBU) || (ld == LD_LHU);
    endfunction

endpackage

// File: rtl/lsu_ldext.sv
// Load data extraction: picks the byte/halfword addressed by the latched
// offset out of the returned word and sign- or zero-extends it.
module lsu_ldext
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  ld_type_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select for byte and halfword accesses.
    always_comb begin
        byte_sel = rdata_i[7:0];
        case (off_i)
            2'd0: byte_sel = rdata_i[7:0];
            2'd1: byte_sel = rdata_i[15:8];
            2'd2: byte_sel = rdata_i[23:16];
            2'd3: byte_sel = rdata_i[31:24];
            default: byte_sel = rdata_i[7:0];
        endcase
        half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    // Extension according to load type; word and unknown codes pass the word.
    always_comb begin
        data_o = rdata_i;
        case (ld_type_i)
            LD_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            LD_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            LD_LBU:  data_o = {24'd0, byte_sel};
            LD_LHU:  data_o = {16'd0, half_sel};
            LD_LW:   data_o = rdata_i;
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: issues data-memory requests for loads and stores, holds
// the execute stage with stall while an access is outstanding and produces
// the registered write-back bundle.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (traps misaligned half/word
// accesses instead of silently ignoring the low address bits).
//
//  state  | meaning
//  IDLE   | no access outstanding; memory op requests combinationally
//  REQ    | request presented, waiting for dmem_gnt
//  WAIT   | load granted, waiting for dmem_rvalid
module lsu
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [WIDTH-1:0] Rd2_exe2lsu,
    input  logic [1:0]       Memtoreg_exe2lsu,
    input  logic [2:0]       Ld_cntr_exe2lsu,
    input  logic [1:0]       St_cntr_exe2lsu,
    input  logic             RegW_exe2lsu,
    input  logic [4:0]       wr_addr_exe2lsu,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [3:0]       dmem_be,
    output logic [WIDTH-1:0] dmem_wdata,
    input  logic             dmem_gnt,
    input  logic             dmem_rvalid,
    input  logic [WIDTH-1:0] dmem_rdata,
    output logic             stall,
    output logic [WIDTH-1:0] wb_data,
    output logic             RegW_lsu2wb,
    output logic [4:0]       wr_addr_lsu2wb,
    output logic             misalign_err
);

    lsu_state_t  state_q;
    logic [31:0] wb_data_q;
    logic        regw_q;
    logic [4:0]  wr_addr_q;
    logic        mis_q;
    logic [1:0]  off_q;
    logic [2:0]  ld_q;
    logic [1:0]  mtr_q;
    logic        regw_ld_q;
    logic [4:0]  rd_ld_q;

    logic        is_st_op;
    logic        is_ld_op;
    logic        mem_op;
    logic        misalign;
    logic        load_grant;
    logic [31:0] ld_ext;

    // Decode the incoming op; a store code wins over a simultaneous load code.
    always_comb begin
        is_st_op = (St_cntr_exe2lsu != ST_NONE);
        is_ld_op = !is_st_op && is_load_code(Ld_cntr_exe2lsu);
        mem_op   = is_st_op || is_ld_op;
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // Halfword needs addr[0]=0, word needs addr[1:0]=00.
    always_comb begin
        misalign = 1'b0;
        if ((is_st_op && St_cntr_exe2lsu == ST_SH) ||
            (is_ld_op && (Ld_cntr_exe2lsu == LD_LH || Ld_cntr_exe2lsu == LD_LHU)))
            misalign = alu_result[0];
        else if ((is_st_op && St_cntr_exe2lsu == ST_SW) ||
                 (is_ld_op && Ld_cntr_exe2lsu == LD_LW))
            misalign = (alu_result[1:0] != 2'b00);
    end
`else
    assign misalign = 1'b0;
`endif

    // Byte enables and lane-replicated store data from the current op.
    always_comb begin
        dmem_addr  = {alu_result[31:2], 2'b00};
        dmem_be    = 4'b1111;
        dmem_wdata = Rd2_exe2lsu;
        if (is_st_op) begin
            case (St_cntr_exe2lsu)
                ST_SB: begin
                    dmem_be    = 4'b0001 << alu_result[1:0];
                    dmem_wdata = {4{Rd2_exe2lsu[7:0]}};
                end
                ST_SH: begin
                    dmem_be    = 4'b0011 << {alu_result[1], 1'b0};
                    dmem_wdata = {2{Rd2_exe2lsu[15:0]}};
                end
                default: begin
                    dmem_be    = 4'b1111;
                    dmem_wdata = Rd2_exe2lsu;
                end
            endcase
        end
    end

    // Request and stall; the execute stage holds the op stable while stalled,
    // so the request fields stay valid through REQ. Reset forces both low.
    always_comb begin
        dmem_req = 1'b0;
        stall    = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_IDLE: begin
                    if (mem_op && !misalign) begin
                        dmem_req = 1'b1;
                        stall    = !(is_st_op && dmem_gnt);
                    end
                end
                S_REQ: begin
                    dmem_req = 1'b1;
                    stall    = !(is_st_op && dmem_gnt);
                end
                S_WAIT: begin
                    stall = !dmem_rvalid;
                end
                default: begin
                    dmem_req = 1'b0;
                    stall    = 1'b0;
                end
            endcase
        end
        dmem_we    = dmem_req && is_st_op;
        load_grant = dmem_req && dmem_gnt && is_ld_op;
    end

    lsu_ldext u_ldext (
        .rdata_i   (dmem_rdata),
        .off_i     (off_q),
        .ld_type_i (ld_q),
        .data_o    (ld_ext)
    );

    // FSM and registered write-back bundle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wb_data_q <= '0;
            regw_q    <= 1'b0;
            wr_addr_q <= '0;
            mis_q     <= 1'b0;
            off_q     <= '0;
            ld_q      <= LD_NONE;
            mtr_q     <= '0;
            regw_ld_q <= 1'b0;
            rd_ld_q   <= '0;
        end else begin
            mis_q <= 1'b0;
            if (load_grant) begin
                off_q     <= alu_result[1:0];
                ld_q      <= Ld_cntr_exe2lsu;
                mtr_q     <= Memtoreg_exe2lsu;
                regw_ld_q <= RegW_exe2lsu;
                rd_ld_q   <= wr_addr_exe2lsu;
            end
            case (state_q)
                S_IDLE: begin
                    if (mem_op) begin
                        regw_q <= 1'b0;
                        if (misalign)
                            mis_q <= 1'b1;
                        else if (!dmem_gnt)
                            state_q <= S_REQ;
                        else if (is_ld_op)
                            state_q <= S_WAIT;
                    end else begin
                        wb_data_q <= alu_result;
                        regw_q    <= RegW_exe2lsu;
                        wr_addr_q <= wr_addr_exe2lsu;
                    end
                end
                S_REQ: begin
                    regw_q <= 1'b0;
                    if (dmem_gnt)
                        state_q <= is_ld_op ? S_WAIT : S_IDLE;
                end
                S_WAIT: begin
                    regw_q <= 1'b0;
                    if (dmem_rvalid) begin
                        wb_data_q <= (mtr_q == MTR_LOAD) ? ld_ext : alu_result;
                        regw_q    <= regw_ld_q;
                        wr_addr_q <= rd_ld_q;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign wb_data        = wb_data_q;
    assign RegW_lsu2wb    = regw_q;
    assign wr_addr_lsu2wb = wr_addr_q;
    assign misalign_err   = mis_q;

endmodule

// File: tb/tb_lsu.sv
// Directed testbench for lsu: hand-computed vectors for pass-through,
// stores, loads, reset abandonment and the misaligned-word case.
module tb_lsu;
    import lsu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] alu_result;
    logic [31:0] Rd2_exe2lsu;
    logic [1:0]  Memtoreg_exe2lsu;
    logic [2:0]  Ld_cntr_exe2lsu;
    logic [1:0]  St_cntr_exe2lsu;
    logic        RegW_exe2lsu;
    logic [4:0]  wr_addr_exe2lsu;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic [31:0] wb_data;
    logic        RegW_lsu2wb;
    logic [4:0]  wr_addr_lsu2wb;
    logic        misalign_err;

    int vectors = 0;
    int miscompares = 0;

    lsu #(.WIDTH(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .alu_result       (alu_result),
        .Rd2_exe2lsu      (Rd2_exe2lsu),
        .Memtoreg_exe2lsu (Memtoreg_exe2lsu),
        .Ld_cntr_exe2lsu  (Ld_cntr_exe2lsu),
        .St_cntr_exe2lsu  (St_cntr_exe2lsu),
        .RegW_exe2lsu     (RegW_exe2lsu),
        .wr_addr_exe2lsu  (wr_addr_exe2lsu),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_be          (dmem_be),
        .dmem_wdata       (dmem_wdata),
        .dmem_gnt         (dmem_gnt),
        .dmem_rvalid      (dmem_rvalid),
        .dmem_rdata       (dmem_rdata),
        .stall            (stall),
        .wb_data          (wb_data),
        .RegW_lsu2wb      (RegW_lsu2wb),
        .wr_addr_lsu2wb   (wr_addr_lsu2wb),
        .misalign_err     (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        alu_result       = '0;
        Rd2_exe2lsu      = '0;
        Memtoreg_exe2lsu = 2'b00;
        Ld_cntr_exe2lsu  = LD_NONE;
        St_cntr_exe2lsu  = ST_NONE;
        RegW_exe2lsu     = 1'b0;
        wr_addr_exe2lsu  = '0;
        dmem_gnt         = 1'b0;
        dmem_rvalid      = 1'b0;
        dmem_rdata       = '0;
    endtask

    // Load granted in its first cycle; rvalid arrives lat (>=2) cycles later.
    // Returns at the negedge after completion with idle inputs applied.
    task automatic run_load(input logic [2:0] ld, input logic [31:0] addr,
                            input logic [31:0] rdata, input int lat,
                            input logic [4:0] rd, input string tag);
        logic [31:0] waddr;
        waddr = {addr[31:2], 2'b00};
        step();
        idle_inputs();
        Ld_cntr_exe2lsu  = ld;
        Memtoreg_exe2lsu = MTR_LOAD;
        alu_result       = addr;
        RegW_exe2lsu     = 1'b1;
        wr_addr_exe2lsu  = rd;
        dmem_gnt         = 1'b1;
        #1;
        check({tag, "_req"},   {31'd0, dmem_req}, 32'd1);
        check({tag, "_we"},    {31'd0, dmem_we},  32'd0);
        check({tag, "_be"},    {28'd0, dmem_be},  32'hF);
        check({tag, "_addr"},  dmem_addr,         waddr);
        check({tag, "_stall"}, {31'd0, stall},    32'd1);
        step();
        dmem_gnt = 1'b0;
        #1;
        check({tag, "_wait_req"},   {31'd0, dmem_req}, 32'd0);
        check({tag, "_wait_stall"}, {31'd0, stall},    32'd1);
        for (int i = 1; i < lat; i++) step();
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        #1;
        check({tag, "_done_stall"}, {31'd0, stall}, 32'd0);
        step();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        // A store presented during reset must not request or stall.
        St_cntr_exe2lsu = ST_SW;
        alu_result      = 32'h100;
        #1;
        check("rst_req",   {31'd0, dmem_req},     32'd0);
        check("rst_stall", {31'd0, stall},        32'd0);
        step();
        check("rst_wb",    wb_data,               32'd0);
        check("rst_regw",  {31'd0, RegW_lsu2wb},  32'd0);
        check("rst_rd",    {27'd0, wr_addr_lsu2wb}, 32'd0);
        check("rst_mis",   {31'd0, misalign_err}, 32'd0);
        idle_inputs();
        rst_n = 1'b1;

        // ADD pass-through: alu 5 -> rd 7, one-cycle latency, no stall.
        step();
        alu_result      = 32'h5;
        RegW_exe2lsu    = 1'b1;
        wr_addr_exe2lsu = 5'd7;
        #1;
        check("add_stall", {31'd0, stall},    32'd0);
        check("add_req",   {31'd0, dmem_req}, 32'd0);

        // SW 0x100 DEADBEEF, grant after two cycles.
        step();
        check("add_wb",   wb_data,                  32'h5);
        check("add_regw", {31'd0, RegW_lsu2wb},     32'd1);
        check("add_rd",   {27'd0, wr_addr_lsu2wb},  32'd7);
        idle_inputs();
        St_cntr_exe2lsu = ST_SW;
        alu_result      = 32'h100;
        Rd2_exe2lsu     = 32'hDEADBEEF;
        RegW_exe2lsu    = 1'b1;
        #1;
        check("sw_req0",   {31'd0, dmem_req}, 32'd1);
        check("sw_we0",    {31'd0, dmem_we},  32'd1);
        check("sw_be0",    {28'd0, dmem_be},  32'hF);
        check("sw_wdata0", dmem_wdata,        32'hDEADBEEF);
        check("sw_addr0",  dmem_addr,         32'h100);
        check("sw_stall0", {31'd0, stall},    32'd1);
        step();
        #1;
        check("sw_req1",   {31'd0, dmem_req}, 32'd1);
        check("sw_wdata1", dmem_wdata,        32'hDEADBEEF);
        check("sw_stall1", {31'd0, stall},    32'd1);
        step();
        dmem_gnt = 1'b1;
        #1;
        check("sw_req2",   {31'd0, dmem_req}, 32'd1);
        check("sw_stall2", {31'd0, stall},    32'd0);

        // SB 0x103 A5 granted immediately (back-to-back after SW).
        step();
        check("sw_regw", {31'd0, RegW_lsu2wb}, 32'd0);
        idle_inputs();
        St_cntr_exe2lsu = ST_SB;
        alu_result      = 32'h103;
        Rd2_exe2lsu     = 32'h000000A5;
        dmem_gnt        = 1'b1;
        #1;
        check("sb_req",   {31'd0, dmem_req}, 32'd1);
        check("sb_be",    {28'd0, dmem_be},  32'h8);
        check("sb_wdata", dmem_wdata,        32'hA5A5A5A5);
        check("sb_addr",  dmem_addr,         32'h100);
        check("sb_stall", {31'd0, stall},    32'd0);

        // SH 0x102 -> upper half lanes.
        step();
        idle_inputs();
        St_cntr_exe2lsu = ST_SH;
        alu_result      = 32'h102;
        Rd2_exe2lsu     = 32'h1234ABCD;
        dmem_gnt        = 1'b1;
        #1;
        check("sh_be",    {28'd0, dmem_be}, 32'hC);
        check("sh_wdata", dmem_wdata,       32'hABCDABCD);
        check("sh_we",    {31'd0, dmem_we}, 32'd1);

        // LB 0x102, rdata 0x00800000, rvalid 3 cycles after grant.
        run_load(LD_LB, 32'h102, 32'h00800000, 3, 5'd9, "lb");
        check("lb_wb",   wb_data,                 32'hFFFFFF80);
        check("lb_regw", {31'd0, RegW_lsu2wb},    32'd1);
        check("lb_rd",   {27'd0, wr_addr_lsu2wb}, 32'd9);

        run_load(LD_LBU, 32'h102, 32'h00800000, 3, 5'd10, "lbu");
        check("lbu_wb", wb_data, 32'h00000080);

        run_load(LD_LH, 32'h102, 32'h80011234, 2, 5'd11, "lh");
        check("lh_wb", wb_data, 32'hFFFF8001);

        run_load(LD_LHU, 32'h100, 32'h80011234, 2, 5'd12, "lhu");
        check("lhu_wb", wb_data, 32'h00001234);

        run_load(LD_LW, 32'h104, 32'hCAFEF00D, 2, 5'd13, "lw");
        check("lw_wb", wb_data, 32'hCAFEF00D);

`ifdef LSU_MISALIGN_TRAP_EN
        step();
        idle_inputs();
        Ld_cntr_exe2lsu  = LD_LW;
        Memtoreg_exe2lsu = MTR_LOAD;
        alu_result       = 32'h101;
        RegW_exe2lsu     = 1'b1;
        wr_addr_exe2lsu  = 5'd14;
        #1;
        check("mis_req",   {31'd0, dmem_req}, 32'd0);
        check("mis_stall", {31'd0, stall},    32'd0);
        step();
        idle_inputs();
        #1;
        check("mis_err",  {31'd0, misalign_err}, 32'd1);
        check("mis_regw", {31'd0, RegW_lsu2wb},  32'd0);
        check("mis_req2", {31'd0, dmem_req},     32'd0);
        step();
        check("mis_err_clr", {31'd0, misalign_err}, 32'd0);
`else
        run_load(LD_LW, 32'h101, 32'h11223344, 2, 5'd14, "lwmis");
        check("lwmis_wb",  wb_data,                32'h11223344);
        check("lwmis_err", {31'd0, misalign_err},  32'd0);
`endif

        // Reset while in WAIT, then a late rvalid must be ignored.
        step();
        idle_inputs();
        Ld_cntr_exe2lsu  = LD_LW;
        Memtoreg_exe2lsu = MTR_LOAD;
        alu_result       = 32'h200;
        RegW_exe2lsu     = 1'b1;
        wr_addr_exe2lsu  = 5'd15;
        dmem_gnt         = 1'b1;
        step();
        dmem_gnt = 1'b0;
        #1;
        check("rw_wait_stall", {31'd0, stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rw_rst_stall", {31'd0, stall},    32'd0);
        check("rw_rst_req",   {31'd0, dmem_req}, 32'd0);
        check("rw_rst_wb",    wb_data,           32'd0);
        step();
        rst_n = 1'b1;
        idle_inputs();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hFFFFFFFF;
        #1;
        check("rw_late_stall", {31'd0, stall}, 32'd0);
        step();
        check("rw_late_wb",   wb_data,              32'd0);
        check("rw_late_regw", {31'd0, RegW_lsu2wb}, 32'd0);
        // FSM must be back in IDLE: a granted store completes without stall.
        idle_inputs();
        St_cntr_exe2lsu = ST_SW;
        alu_result      = 32'h300;
        Rd2_exe2lsu     = 32'h01020304;
        dmem_gnt        = 1'b1;
        #1;
        check("rw_idle_req",   {31'd0, dmem_req}, 32'd1);
        check("rw_idle_stall", {31'd0, stall},    32'd0);

        // Memtoreg=01 with no load active writes back alu_result.
        step();
        idle_inputs();
        Memtoreg_exe2lsu = MTR_LOAD;
        alu_result       = 32'h00001234;
        RegW_exe2lsu     = 1'b1;
        wr_addr_exe2lsu  = 5'd4;
        #1;
        check("mtr_req", {31'd0, dmem_req}, 32'd0);
        step();
        idle_inputs();
        check("mtr_wb",   wb_data,                 32'h00001234);
        check("mtr_regw", {31'd0, RegW_lsu2wb},    32'd1);
        check("mtr_rd",   {27'd0, wr_addr_lsu2wb}, 32'd4);

        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
